breakout_engine: RTL and testbench
==================================

Name: breakout_engine

Overview:
- Parametrised brick-breaker game engine: paddle, ball physics, brick grid, score, lives, speed phases.
- Sits between the button debouncers/frame-tick generator and the VGA pixel renderer. Outputs positions, brick bitmap and game state only; no pixel colouring.
- Runs on the fast system clock and advances one step per frame-tick pulse. Grid size, geometry, lives and speed ramp are parameters.

Parameters:
- ROWS, 5, brick rows
- COLS, 12, brick columns
- X_MIN, 144, left wall x
- X_MAX, 783, right wall x
- Y_MIN, 35, ceiling y
- Y_FLOOR, 515, floor y
- BRICK_W, 53, brick width px
- BRICK_H, 25, brick height px
- BALL_R, 5, ball half-size px
- PADDLE_HW, 25, paddle half-width px
- PADDLE_HH, 5, paddle half-height px
- PADDLE_Y, 500, paddle centre y (fixed)
- PADDLE_STEP, 2, paddle px per tick
- SERVE_X, 480, ball serve x
- SERVE_Y, 200, ball serve y
- LIVES, 3, lives per game (1..15)
- PHASE_PTS, 20, points per speed increment
- MAX_SPEED, 3, ball px per tick cap

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- tick  in  1  one-cycle frame-step pulse
- start  in  1  start/serve button (level, sampled on tick)
- left  in  1  paddle left (level)
- right  in  1  paddle right (level)
- paddle_x  out  10  paddle centre x
- ball_x  out  10  ball centre x
- ball_y  out  10  ball centre y
- bricks_alive  out  ROWS*COLS  bit r*COLS+c set = brick present
- score_ones  out  4  BCD units
- score_tens  out  4  BCD tens
- lives  out  4  remaining lives
- state  out  3  game state code

Behaviour:
- Reset (rst=0, async) values: state=SERVE, paddle_x=(X_MIN+X_MAX)/2 truncated =463, ball=(SERVE_X,SERVE_Y), dx=+1, dy=+1, speed=1, all bricks_alive=1, score=00, lives=LIVES.
- Reset asserted mid-game gives the same values immediately.
- All updates occur only on clk edges where tick=1. With tick=0, all registers hold.
- States: SERVE, PLAY, WIN, LOSE.
- SERVE: ball held at the serve point. start=1 -> PLAY.
- WIN/LOSE: everything frozen. start=1 -> full re-init (reset values) into SERVE.
- Paddle, in SERVE and PLAY:
  - right only: +PADDLE_STEP.
  - left only: -PADDLE_STEP.
  - both or neither: hold.
  - Clamped to [X_MIN+PADDLE_HW, X_MAX-PADDLE_HW] = [169, 758].
- PLAY step: compute collisions on the current position, update directions, then move the ball by dx*speed, dy*speed. Collision checks, in priority order, at most one per tick:
  1. Floor: ball_y+BALL_R >= Y_FLOOR. lives-1. If the new value is 0 -> LOSE, else -> SERVE; ball re-served. No move this tick.
  2. Paddle: dy=+1 and ball_y+BALL_R >= PADDLE_Y-PADDLE_HH and x-extents overlap the paddle -> dy=-1.
  3. Wall: (dx=+1 and ball_x+BALL_R >= X_MAX) or (dx=-1 and ball_x-BALL_R <= X_MIN) -> dx flips.
  4. Ceiling: dy=-1 and ball_y-BALL_R <= Y_MIN -> dy=+1.
  5. Brick: lowest-index alive brick whose box (inclusive) overlaps the ball box. Clear its bit, score+1, dy flips. Exactly one brick per tick.
- Brick (r,c) box: x in [X_MIN+c*BRICK_W, X_MIN+(c+1)*BRICK_W], y in [Y_MIN+r*BRICK_H, Y_MIN+(r+1)*BRICK_H].
- Score is BCD. Units 9 -> 0 with tens+1. Saturates at 99.
- Speed: speed = min(1 + points/PHASE_PTS, MAX_SPEED), recomputed every tick from the internal binary point count.
- Last brick cleared -> WIN on the same tick. WIN takes priority over the move.
- Geometry arithmetic is unsigned, 11-bit internally, so x-BALL_R cannot wrap below 0.

Optional Feature:
- Macro BREAKOUT_MULTIHIT_EN.
- Defined: row 0 bricks need 2 hits. The first hit sets a per-brick cracked bit (output cracked, width COLS), flips dy, and adds no score. The second hit clears the brick and adds score+1.
- Undefined: all bricks are single-hit; the cracked port does not exist.

Decomposition:
- Package breakout_pkg: state encoding (SERVE=0, PLAY=1, WIN=2, LOSE=3), default geometry constants, BCD increment function.
- Sub-module breakout_brick_hit: combinational overlap of ball box against the grid, priority encoder giving hit flag and index. Instantiated once.

Test Plan:
- Reset: rst=0 mid-PLAY -> state=SERVE, paddle_x=463, ball=(480,200), score=00, lives=3, bricks_alive all ones.
- Serve/motion: start for 1 tick, then 3 ticks -> ball=(483,203). Right held 400 ticks -> paddle_x clamps at 758.
- Paddle bounce: paddle at 758, serve. At tick 290 ball=(770,490) -> dy=-1; next tick ball_y=489.
- Miss: paddle at 169, serve -> on floor contact lives 3->2, state=SERVE, ball=(480,200). Repeat twice -> lives=0, LOSE; start -> SERVE, lives=3.
- Brick/score: rising ball overlapping two bricks -> only the lower index cleared, score +1, dy=+1. Score at 09 plus a hit -> 10. Score at 99 plus a hit -> 99. Speed=2 after 20 points.
- Win: ROWS=1, COLS=1 -> first brick hit gives bricks_alive=0 and state=WIN; tick with no start -> frozen.

Source files
------------

// File: rtl/breakout_pkg.sv
// Shared types and constants for the brick-breaker engine: game state encoding,
// default geometry and the saturating two-digit BCD increment.
package breakout_pkg;

    typedef enum logic [2:0] {
        StServe = 3'd0,
        StPlay  = 3'd1,
        StWin   = 3'd2,
        StLose  = 3'd3
    } game_state_e;

    localparam int unsigned DefRows       = 5;
    localparam int unsigned DefCols       = 12;
    localparam int unsigned DefXMin       = 144;
    localparam int unsigned DefXMax       = 783;
    localparam int unsigned DefYMin       = 35;
    localparam int unsigned DefYFloor     = 515;
    localparam int unsigned DefBrickW     = 53;
    localparam int unsigned DefBrickH     = 25;
    localparam int unsigned DefBallR      = 5;
    localparam int unsigned DefPaddleHw   = 25;
    localparam int unsigned DefPaddleHh   = 5;
    localparam int unsigned DefPaddleY    = 500;
    localparam int unsigned DefPaddleStep = 2;
    localparam int unsigned DefServeX     = 480;
    localparam int unsigned DefServeY     = 200;
    localparam int unsigned DefLives      = 3;
    localparam int unsigned DefPhasePts   = 20;
    localparam int unsigned DefMaxSpeed   = 3;

    // {tens, ones} BCD increment that sticks at 99.
    function automatic logic [7:0] bcd_inc(input logic [7:0] bcd);
        if (bcd == 8'h99) begin
            return 8'h99;
        end
        if (bcd[3:0] == 4'd9) begin
            return {bcd[7:4] + 4'd1, 4'd0};
        end
        return {bcd[7:4], bcd[3:0] + 4'd1};
    endfunction

endpackage

// File: rtl/breakout_brick_hit.sv
// Combinational ball-versus-grid overlap test; reports the lowest-index live
// brick whose inclusive box touches the ball box.
module breakout_brick_hit
    import breakout_pkg::*;
#(
    parameter int unsigned ROWS    = DefRows,
    parameter int unsigned COLS    = DefCols,
    parameter int unsigned X_MIN   = DefXMin,
    parameter int unsigned Y_MIN   = DefYMin,
    parameter int unsigned BRICK_W = DefBrickW,
    parameter int unsigned BRICK_H = DefBrickH,
    parameter int unsigned BALL_R  = DefBallR,
    parameter int unsigned IDX_W   = 6
) (
    input  logic [10:0]          ball_x,
    input  logic [10:0]          ball_y,
    input  logic [ROWS*COLS-1:0] alive,
    output logic                 hit,
    output logic [IDX_W-1:0]     idx
);

    localparam logic [10:0] BallR = 11'(BALL_R);

    always_comb begin
        hit = 1'b0;
        idx = '0;
        // Scan downwards so the lowest matching index is the one left standing.
        for (int r = int'(ROWS) - 1; r >= 0; r--) begin
            for (int c = int'(COLS) - 1; c >= 0; c--) begin
                if (alive[r*COLS+c] &&
                    ball_x + BallR >= 11'(X_MIN + c*BRICK_W) &&
                    ball_x - BallR <= 11'(X_MIN + (c+1)*BRICK_W) &&
                    ball_y + BallR >= 11'(Y_MIN + r*BRICK_H) &&
                    ball_y - BallR <= 11'(Y_MIN + (r+1)*BRICK_H)) begin
                    hit = 1'b1;
                    idx = IDX_W'(r*COLS + c);
                end
            end
        end
    end

endmodule

// File: rtl/breakout_engine.sv
// Brick-breaker game engine stepping once per frame tick. Define
// BREAKOUT_MULTIHIT_EN to make row-0 bricks take two hits (adds the cracked port).
module breakout_engine
    import breakout_pkg::*;
#(
    parameter int unsigned ROWS        = DefRows,
    parameter int unsigned COLS        = DefCols,
    parameter int unsigned X_MIN       = DefXMin,
    parameter int unsigned X_MAX       = DefXMax,
    parameter int unsigned Y_MIN       = DefYMin,
    parameter int unsigned Y_FLOOR     = DefYFloor,
    parameter int unsigned BRICK_W     = DefBrickW,
    parameter int unsigned BRICK_H     = DefBrickH,
    parameter int unsigned BALL_R      = DefBallR,
    parameter int unsigned PADDLE_HW   = DefPaddleHw,
    parameter int unsigned PADDLE_HH   = DefPaddleHh,
    parameter int unsigned PADDLE_Y    = DefPaddleY,
    parameter int unsigned PADDLE_STEP = DefPaddleStep,
    parameter int unsigned SERVE_X     = DefServeX,
    parameter int unsigned SERVE_Y     = DefServeY,
    parameter int unsigned LIVES       = DefLives,
    parameter int unsigned PHASE_PTS   = DefPhasePts,
    parameter int unsigned MAX_SPEED   = DefMaxSpeed
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick,
    input  logic                 start,
    input  logic                 left,
    input  logic                 right,
    output logic [9:0]           paddle_x,
    output logic [9:0]           ball_x,
    output logic [9:0]           ball_y,
    output logic [ROWS*COLS-1:0] bricks_alive,
    output logic [3:0]           score_ones,
    output logic [3:0]           score_tens,
    output logic [3:0]           lives,
    output logic [2:0]           state
`ifdef BREAKOUT_MULTIHIT_EN
    ,
    output logic [COLS-1:0]      cracked
`endif
);

    localparam int unsigned NB    = ROWS * COLS;
    localparam int unsigned IDX_W = (NB > 1) ? $clog2(NB) : 1;

    localparam logic [10:0] WallL   = 11'(X_MIN);
    localparam logic [10:0] WallR   = 11'(X_MAX);
    localparam logic [10:0] Ceil    = 11'(Y_MIN);
    localparam logic [10:0] Floor   = 11'(Y_FLOOR);
    localparam logic [10:0] BallR   = 11'(BALL_R);
    localparam logic [10:0] PadHw   = 11'(PADDLE_HW);
    localparam logic [10:0] PadTop  = 11'(PADDLE_Y - PADDLE_HH);
    localparam logic [10:0] PadStep = 11'(PADDLE_STEP);
    localparam logic [10:0] PadMin  = 11'(X_MIN + PADDLE_HW);
    localparam logic [10:0] PadMax  = 11'(X_MAX - PADDLE_HW);
    localparam logic [9:0]  PadRst  = 10'((X_MIN + X_MAX) / 2);
    localparam logic [9:0]  ServeX  = 10'(SERVE_X);
    localparam logic [9:0]  ServeY  = 10'(SERVE_Y);

    game_state_e     state_q, state_d;
    logic [9:0]      paddle_q, paddle_d, bx_q, bx_d, by_q, by_d;
    logic            dx_q, dx_d, dy_q, dy_d;  // 1 = moving towards larger coordinate
    logic [NB-1:0]   alive_q, alive_d;
    logic [3:0]      ones_q, ones_d, tens_q, tens_d, lives_q, lives_d;
    logic [6:0]      points_q, points_d;

    logic [10:0]     px, bx, by, speed, paddle_mv;
    int unsigned     phase;
    logic            hit, hit_clear;
    logic [IDX_W-1:0] hit_idx;

`ifdef BREAKOUT_MULTIHIT_EN
    localparam int unsigned COL_W = (COLS > 1) ? $clog2(COLS) : 1;
    logic [COLS-1:0]  cracked_q, cracked_d;
    logic [COL_W-1:0] hit_col;
    assign hit_col = COL_W'(hit_idx);
    assign cracked = cracked_q;
`endif

    assign px = {1'b0, paddle_q};
    assign bx = {1'b0, bx_q};
    assign by = {1'b0, by_q};

    breakout_brick_hit #(
        .ROWS    (ROWS),
        .COLS    (COLS),
        .X_MIN   (X_MIN),
        .Y_MIN   (Y_MIN),
        .BRICK_W (BRICK_W),
        .BRICK_H (BRICK_H),
        .BALL_R  (BALL_R),
        .IDX_W   (IDX_W)
    ) u_brick_hit (
        .ball_x (bx),
        .ball_y (by),
        .alive  (alive_q),
        .hit    (hit),
        .idx    (hit_idx)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StServe;
            paddle_q <= PadRst;
            bx_q     <= ServeX;
            by_q     <= ServeY;
            dx_q     <= 1'b1;
            dy_q     <= 1'b1;
            alive_q  <= '1;
            ones_q   <= 4'd0;
            tens_q   <= 4'd0;
            points_q <= 7'd0;
            lives_q  <= 4'(LIVES);
`ifdef BREAKOUT_MULTIHIT_EN
            cracked_q <= '0;
`endif
        end else if (tick) begin
            state_q  <= state_d;
            paddle_q <= paddle_d;
            bx_q     <= bx_d;
            by_q     <= by_d;
            dx_q     <= dx_d;
            dy_q     <= dy_d;
            alive_q  <= alive_d;
            ones_q   <= ones_d;
            tens_q   <= tens_d;
            points_q <= points_d;
            lives_q  <= lives_d;
`ifdef BREAKOUT_MULTIHIT_EN
            cracked_q <= cracked_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        paddle_d  = paddle_q;
        bx_d      = bx_q;
        by_d      = by_q;
        dx_d      = dx_q;
        dy_d      = dy_q;
        alive_d   = alive_q;
        ones_d    = ones_q;
        tens_d    = tens_q;
        points_d  = points_q;
        lives_d   = lives_q;
        hit_clear = 1'b0;
`ifdef BREAKOUT_MULTIHIT_EN
        cracked_d = cracked_q;
`endif
        phase = 32'(points_q) / PHASE_PTS + 1;
        speed = (phase > MAX_SPEED) ? 11'(MAX_SPEED) : 11'(phase);

        if (right && !left) begin
            paddle_mv = (px + PadStep > PadMax) ? PadMax : px + PadStep;
        end else if (left && !right) begin
            paddle_mv = (px < PadMin + PadStep) ? PadMin : px - PadStep;
        end else begin
            paddle_mv = px;
        end

        unique case (state_q)
            StServe: begin
                paddle_d = paddle_mv[9:0];
                if (start) state_d = StPlay;
            end
            StPlay: begin
                paddle_d = paddle_mv[9:0];
                if (by + BallR >= Floor) begin
                    lives_d = lives_q - 4'd1;
                    state_d = (lives_d == 4'd0) ? StLose : StServe;
                    bx_d    = ServeX;
                    by_d    = ServeY;
                    dx_d    = 1'b1;
                    dy_d    = 1'b1;
                end else begin
                    // Only the highest-priority collision is serviced this tick.
                    if (dy_q && by + BallR >= PadTop &&
                        bx + BallR >= px - PadHw && bx - BallR <= px + PadHw) begin
                        dy_d = 1'b0;
                    end else if ((dx_q && bx + BallR >= WallR) ||
                                 (!dx_q && bx - BallR <= WallL)) begin
                        dx_d = !dx_q;
                    end else if (!dy_q && by - BallR <= Ceil) begin
                        dy_d = 1'b1;
                    end else if (hit) begin
                        dy_d      = !dy_q;
                        hit_clear = 1'b1;
`ifdef BREAKOUT_MULTIHIT_EN
                        if (32'(hit_idx) < COLS && !cracked_q[hit_col]) begin
                            hit_clear          = 1'b0;
                            cracked_d[hit_col] = 1'b1;
                        end
`endif
                        if (hit_clear) begin
                            alive_d[hit_idx] = 1'b0;
                            {tens_d, ones_d} = bcd_inc({tens_q, ones_q});
                            points_d = (points_q == 7'd99) ? points_q : points_q + 7'd1;
                        end
                    end
                    if (alive_d == '0) begin
                        state_d = StWin;
                    end else begin
                        bx_d = dx_d ? 10'(bx + speed) : 10'(bx - speed);
                        by_d = dy_d ? 10'(by + speed) : 10'(by - speed);
                    end
                end
            end
            StWin, StLose: begin
                if (start) begin
                    state_d  = StServe;
                    paddle_d = PadRst;
                    bx_d     = ServeX;
                    by_d     = ServeY;
                    dx_d     = 1'b1;
                    dy_d     = 1'b1;
                    alive_d  = '1;
                    ones_d   = 4'd0;
                    tens_d   = 4'd0;
                    points_d = 7'd0;
                    lives_d  = 4'(LIVES);
`ifdef BREAKOUT_MULTIHIT_EN
                    cracked_d = '0;
`endif
                end
            end
            default: state_d = StServe;
        endcase
    end

    assign paddle_x     = paddle_q;
    assign ball_x       = bx_q;
    assign ball_y       = by_q;
    assign bricks_alive = alive_q;
    assign score_ones   = ones_q;
    assign score_tens   = tens_q;
    assign lives        = lives_q;
    assign state        = state_q;

endmodule

// File: tb/tb_breakout_engine.sv
// Bench for breakout_engine: vector tables, directed corner sequences and a
// randomized paddle-tracking game compared against a behavioural game model.
module tb_breakout_engine;
    import breakout_pkg::*;

    localparam int ROWS = 5;
    localparam int COLS = 12;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, tick, start, left, right;
    logic [9:0] paddle_x, ball_x, ball_y;
    logic [ROWS*COLS-1:0] bricks_alive;
    logic [3:0] score_ones, score_tens, lives;
    logic [2:0] state;

    logic w_tick, w_start;
    logic [9:0] w_paddle_x, w_ball_x, w_ball_y;
    logic [0:0] w_bricks;
    logic [3:0] w_ones, w_tens, w_lives;
    logic [2:0] w_state;
`ifdef BREAKOUT_MULTIHIT_EN
    logic [COLS-1:0] cracked;
    logic [0:0] w_cracked;
`endif

    breakout_engine dut (
        .clk(clk), .rst(rst), .tick(tick), .start(start), .left(left), .right(right),
        .paddle_x(paddle_x), .ball_x(ball_x), .ball_y(ball_y), .bricks_alive(bricks_alive),
        .score_ones(score_ones), .score_tens(score_tens), .lives(lives), .state(state)
`ifdef BREAKOUT_MULTIHIT_EN
        , .cracked(cracked)
`endif
    );

    // One brick spanning the whole playfield with the ball served inside it.
    breakout_engine #(.ROWS(1), .COLS(1), .BRICK_W(639), .SERVE_Y(62)) dut_w (
        .clk(clk), .rst(rst), .tick(w_tick), .start(w_start), .left(1'b0), .right(1'b0),
        .paddle_x(w_paddle_x), .ball_x(w_ball_x), .ball_y(w_ball_y), .bricks_alive(w_bricks),
        .score_ones(w_ones), .score_tens(w_tens), .lives(w_lives), .state(w_state)
`ifdef BREAKOUT_MULTIHIT_EN
        , .cracked(w_cracked)
`endif
    );

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: 0 serve, 1 play, 2 win, 3 lose.
    int m_state, m_px, m_bx, m_by, m_dx, m_dy, m_pts, m_lives;
    bit m_brick[ROWS][COLS];

    task automatic m_reset();
        m_state = 0; m_px = 463; m_bx = 480; m_by = 200;
        m_dx = 1; m_dy = 1; m_pts = 0; m_lives = 3;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) m_brick[r][c] = 1'b1;
    endtask

    function automatic logic [63:0] m_vec();
        logic [63:0] v = '0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) v[r*COLS+c] = m_brick[r][c];
        return v;
    endfunction

    task automatic m_step(input bit s, input bit lf, input bit rt);
        int old_px, spd, left_cnt;
        bit done;
        old_px = m_px;
        if (m_state <= 1) begin
            if (rt && !lf) m_px = (m_px + 2 > 758) ? 758 : m_px + 2;
            else if (lf && !rt) m_px = (m_px - 2 < 169) ? 169 : m_px - 2;
        end
        if (m_state == 0) begin
            if (s) m_state = 1;
        end else if (m_state == 1) begin
            spd = 1 + m_pts / 20;
            if (spd > 3) spd = 3;
            if (m_by + 5 >= 515) begin
                m_lives--;
                m_state = (m_lives == 0) ? 3 : 0;
                m_bx = 480; m_by = 200; m_dx = 1; m_dy = 1;
            end else begin
                if (m_dy > 0 && m_by + 5 >= 495 && m_bx - old_px <= 30 && old_px - m_bx <= 30)
                    m_dy = -1;
                else if ((m_dx > 0 && m_bx + 5 >= 783) || (m_dx < 0 && m_bx - 5 <= 144))
                    m_dx = -m_dx;
                else if (m_dy < 0 && m_by - 5 <= 35)
                    m_dy = 1;
                else begin
                    done = 0;
                    for (int r = 0; r < ROWS; r++)
                        for (int c = 0; c < COLS; c++)
                            if (!done && m_brick[r][c] &&
                                m_bx + 5 >= 144 + c*53 && m_bx - 5 <= 144 + (c+1)*53 &&
                                m_by + 5 >= 35 + r*25 && m_by - 5 <= 35 + (r+1)*25) begin
                                m_brick[r][c] = 1'b0;
                                done = 1;
                                m_pts = (m_pts < 99) ? m_pts + 1 : 99;
                                m_dy = -m_dy;
                            end
                end
                left_cnt = 0;
                for (int r = 0; r < ROWS; r++)
                    for (int c = 0; c < COLS; c++) left_cnt += int'(m_brick[r][c]);
                if (left_cnt == 0) m_state = 2;
                else begin
                    m_bx += m_dx * spd;
                    m_by += m_dy * spd;
                end
            end
        end else if (s) begin
            m_reset();
        end
    endtask

    task automatic cmp_all();
        check("paddle_x", 64'(paddle_x), 64'(m_px));
        check("ball_x", 64'(ball_x), 64'(m_bx));
        check("ball_y", 64'(ball_y), 64'(m_by));
        check("state", 64'(state), 64'(m_state));
        check("lives", 64'(lives), 64'(m_lives));
        check("score_ones", 64'(score_ones), 64'(m_pts % 10));
        check("score_tens", 64'(score_tens), 64'(m_pts / 10));
        check("bricks_alive", 64'(bricks_alive), m_vec());
    endtask

    task automatic step(input bit s, input bit lf, input bit rt);
        @(negedge clk);
        start = s; left = lf; right = rt; tick = 1'b1;
        @(posedge clk);
        #1 tick = 1'b0;
        m_step(s, lf, rt);
        cmp_all();
    endtask

    task automatic wstep(input bit s);
        @(negedge clk);
        w_start = s; w_tick = 1'b1;
        @(posedge clk);
        #1 w_tick = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        m_reset();
    endtask

    typedef struct {
        bit s; bit l; bit r;
        int px; int bx; int by; int st;
    } vec_t;

    typedef struct {
        logic [7:0] in;
        logic [7:0] exp;
    } bcd_t;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[9];
        bcd_t bt[5];
        int n, max_pts;
        bit s, lf, rt;

        tbl[0] = '{1'b0, 1'b0, 1'b0, 463, 480, 200, 0};
        tbl[1] = '{1'b0, 1'b0, 1'b1, 465, 480, 200, 0};
        tbl[2] = '{1'b0, 1'b1, 1'b0, 463, 480, 200, 0};
        tbl[3] = '{1'b0, 1'b1, 1'b1, 463, 480, 200, 0};
        tbl[4] = '{1'b1, 1'b0, 1'b0, 463, 480, 200, 1};
        tbl[5] = '{1'b0, 1'b0, 1'b0, 463, 481, 201, 1};
        tbl[6] = '{1'b0, 1'b0, 1'b0, 463, 482, 202, 1};
        tbl[7] = '{1'b0, 1'b0, 1'b0, 463, 483, 203, 1};
        tbl[8] = '{1'b0, 1'b1, 1'b0, 461, 484, 204, 1};

        bt[0] = '{8'h09, 8'h10};
        bt[1] = '{8'h99, 8'h99};
        bt[2] = '{8'h45, 8'h46};
        bt[3] = '{8'h19, 8'h20};
        bt[4] = '{8'h00, 8'h01};

        rst = 1'b0; tick = 1'b0; start = 1'b0; left = 1'b0; right = 1'b0;
        w_tick = 1'b0; w_start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        m_reset();

        for (int i = 0; i < 5; i++) check("bcd_inc", 64'(bcd_inc(bt[i].in)), 64'(bt[i].exp));

        for (int i = 0; i < 9; i++) begin
            step(tbl[i].s, tbl[i].l, tbl[i].r);
            check("tbl_paddle", 64'(paddle_x), 64'(tbl[i].px));
            check("tbl_ball_x", 64'(ball_x), 64'(tbl[i].bx));
            check("tbl_ball_y", 64'(ball_y), 64'(tbl[i].by));
            check("tbl_state", 64'(state), 64'(tbl[i].st));
        end

        // Asynchronous reset in the middle of play, checked before any clock edge.
        #2 rst = 1'b0;
        #1;
        check("rst_state", 64'(state), 64'd0);
        check("rst_paddle", 64'(paddle_x), 64'd463);
        check("rst_ball_x", 64'(ball_x), 64'd480);
        check("rst_ball_y", 64'(ball_y), 64'd200);
        check("rst_score", 64'({score_tens, score_ones}), 64'h00);
        check("rst_lives", 64'(lives), 64'd3);
        check("rst_bricks", 64'(bricks_alive), 64'h0FFF_FFFF_FFFF_FFFF);
        @(negedge clk);
        rst = 1'b1;
        m_reset();

        repeat (400) step(1'b0, 1'b0, 1'b1);
        check("clamp_right", 64'(paddle_x), 64'd758);
        step(1'b1, 1'b0, 1'b0);
        repeat (290) step(1'b0, 1'b0, 1'b0);
        check("bounce_pre_x", 64'(ball_x), 64'd770);
        check("bounce_pre_y", 64'(ball_y), 64'd490);
        step(1'b0, 1'b0, 1'b0);
        check("bounce_post_y", 64'(ball_y), 64'd489);

        do_reset();
        repeat (200) step(1'b0, 1'b1, 1'b0);
        check("clamp_left", 64'(paddle_x), 64'd169);
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 1'b0, 1'b0);
            n = 0;
            while (state == 3'd1 && n < 1000) begin
                step(1'b0, 1'b0, 1'b0);
                n++;
            end
            check("miss_timeout", 64'(n < 1000), 64'd1);
            check("miss_lives", 64'(lives), 64'(2 - k));
            check("miss_state", 64'(state), (k < 2) ? 64'd0 : 64'd3);
            check("miss_ball_x", 64'(ball_x), 64'd480);
            check("miss_ball_y", 64'(ball_y), 64'd200);
        end
        step(1'b1, 1'b0, 1'b0);
        check("restart_state", 64'(state), 64'd0);
        check("restart_lives", 64'(lives), 64'd3);

        // Randomized play with the paddle mostly chasing the ball.
        do_reset();
        max_pts = 0;
        for (int i = 0; i < 30000 && bad < 50; i++) begin
            s = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 9) == 0) begin
                lf = 1'($urandom); rt = 1'($urandom);
            end else begin
                lf = (m_px > m_bx); rt = (m_px < m_bx);
            end
            step(s, lf, rt);
            if (m_pts > max_pts) max_pts = m_pts;
        end
        $display("random play: highest score reached %0d", max_pts);

        // Single-brick grid: the first hit wins, then everything freezes.
        wstep(1'b1);
        check("win_play_state", 64'(w_state), 64'd1);
        check("win_play_bricks", 64'(w_bricks), 64'd1);
        wstep(1'b0);
        check("win_state", 64'(w_state), 64'd2);
        check("win_bricks", 64'(w_bricks), 64'd0);
        check("win_score", 64'({w_tens, w_ones}), 64'h01);
        check("win_ball_y", 64'(w_ball_y), 64'd62);
        wstep(1'b0);
        check("frozen_state", 64'(w_state), 64'd2);
        check("frozen_ball_x", 64'(w_ball_x), 64'd480);
        check("frozen_ball_y", 64'(w_ball_y), 64'd62);
        wstep(1'b1);
        check("win_restart_state", 64'(w_state), 64'd0);
        check("win_restart_bricks", 64'(w_bricks), 64'd1);
        check("win_restart_score", 64'({w_tens, w_ones}), 64'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
